// File: rtl/ex_pkg.sv
// Shared EX-stage constants: ALU function codes, ALUOp encodings, ctrl-bit indices.
package ex_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned RA_W_DEFAULT = 5;

    // ALU function codes consumed by the EX-stage ALU
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRA = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // ALUOp encodings produced by the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IARITH = 2'b11;

    // Bit positions inside the 4-bit ctrl bundle {reg_write, mem_read, mem_write, mem_to_reg}
    localparam int unsigned CTRL_REG_WRITE  = 3;
    localparam int unsigned CTRL_MEM_READ   = 2;
    localparam int unsigned CTRL_MEM_WRITE  = 1;
    localparam int unsigned CTRL_MEM_TO_REG = 0;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: alu_op/funct3/funct7[5] -> 3-bit ALU code.
module alu_ctrl_dec
    import ex_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_ctrl
);

    // Decode the ALU function; I-arith shares R-type except addi never subtracts
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: alu_ctrl = (funct7b5 && (alu_op == ALUOP_RTYPE)) ? ALU_SUB : ALU_ADD;
                    3'b111: alu_ctrl = ALU_AND;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b100: alu_ctrl = ALU_XOR;
                    3'b001: alu_ctrl = ALU_SLL;
                    3'b101: alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding, ALU control decode and load-use bubble insertion.
module id_ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned RA_W = RA_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic [RA_W-1:0] id_rd_i,
    input  logic [2:0]      id_funct3_i,
    input  logic            id_funct7b5_i,
    input  logic [1:0]      id_alu_op_i,
    input  logic            id_alu_src_i,
    input  logic [3:0]      id_ctrl_i,
    input  logic [RA_W-1:0] exm_rd_i,
    input  logic            exm_reg_write_i,
    input  logic [XLEN-1:0] exm_result_i,
    input  logic [RA_W-1:0] mwb_rd_i,
    input  logic            mwb_reg_write_i,
    input  logic [XLEN-1:0] mwb_result_i,
    output logic [XLEN-1:0] data1_o,
    output logic [XLEN-1:0] data2_o,
    output logic [2:0]      ALUCtrl_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [RA_W-1:0] rd_o,
    output logic [3:0]      ctrl_o,
    output logic            valid_o,
    output logic            hazard_o
);

    logic            valid_q;
    logic [3:0]      ctrl_q;
    logic [RA_W-1:0] rd_q;
    logic [RA_W-1:0] rs1_q;
    logic [RA_W-1:0] rs2_q;
    logic [2:0]      funct3_q;
    logic            funct7b5_q;
    logic [1:0]      alu_op_q;
    logic            alu_src_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;

    logic            hazard;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Load in EX whose destination is read by the instruction now in ID
    always_comb begin
        hazard = valid_q && ctrl_q[CTRL_MEM_READ] && (rd_q != '0)
                 && ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));
    end

    // Stage register: flush > stall > load-use bubble > capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            alu_op_q   <= '0;
            alu_src_q  <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else if (flush_i || (!stall_i && hazard)) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
            alu_op_q   <= '0;
            alu_src_q  <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else if (!stall_i) begin
            valid_q    <= 1'b1;
            ctrl_q     <= id_ctrl_i;
            rd_q       <= id_rd_i;
            rs1_q      <= id_rs1_i;
            rs2_q      <= id_rs2_i;
            funct3_q   <= id_funct3_i;
            funct7b5_q <= id_funct7b5_i;
            alu_op_q   <= id_alu_op_i;
            alu_src_q  <= id_alu_src_i;
            rs1_data_q <= id_rs1_data_i;
            rs2_data_q <= id_rs2_data_i;
            imm_q      <= id_imm_i;
        end
    end

    // Operand forwarding: EX/MEM over MEM/WB, x0 never forwarded
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == rs1_q)) begin
            fwd_rs1 = exm_result_i;
        end else if (mwb_reg_write_i && (mwb_rd_i != '0) && (mwb_rd_i == rs1_q)) begin
            fwd_rs1 = mwb_result_i;
        end
        fwd_rs2 = rs2_data_q;
        if (exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == rs2_q)) begin
            fwd_rs2 = exm_result_i;
        end else if (mwb_reg_write_i && (mwb_rd_i != '0) && (mwb_rd_i == rs2_q)) begin
            fwd_rs2 = mwb_result_i;
        end
    end

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op   (alu_op_q),
        .funct3   (funct3_q),
        .funct7b5 (funct7b5_q),
        .alu_ctrl (ALUCtrl_o)
    );

    // Drive ALU operands and downstream pass-through
    always_comb begin
        data1_o      = fwd_rs1;
        data2_o      = alu_src_q ? imm_q : fwd_rs2;
        store_data_o = fwd_rs2;
        rd_o         = rd_q;
        ctrl_o       = ctrl_q;
        valid_o      = valid_q;
        hazard_o     = hazard;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i;
    logic [63:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [2:0]  id_funct3_i;
    logic        id_funct7b5_i;
    logic [1:0]  id_alu_op_i;
    logic        id_alu_src_i;
    logic [3:0]  id_ctrl_i;
    logic [4:0]  exm_rd_i, mwb_rd_i;
    logic        exm_reg_write_i, mwb_reg_write_i;
    logic [63:0] exm_result_i, mwb_result_i;
    logic [63:0] data1_o, data2_o, store_data_o;
    logic [2:0]  ALUCtrl_o;
    logic [4:0]  rd_o;
    logic [3:0]  ctrl_o;
    logic        valid_o, hazard_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .id_rs1_data_i   (id_rs1_data_i),
        .id_rs2_data_i   (id_rs2_data_i),
        .id_imm_i        (id_imm_i),
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .id_rd_i         (id_rd_i),
        .id_funct3_i     (id_funct3_i),
        .id_funct7b5_i   (id_funct7b5_i),
        .id_alu_op_i     (id_alu_op_i),
        .id_alu_src_i    (id_alu_src_i),
        .id_ctrl_i       (id_ctrl_i),
        .exm_rd_i        (exm_rd_i),
        .exm_reg_write_i (exm_reg_write_i),
        .exm_result_i    (exm_result_i),
        .mwb_rd_i        (mwb_rd_i),
        .mwb_reg_write_i (mwb_reg_write_i),
        .mwb_result_i    (mwb_result_i),
        .data1_o         (data1_o),
        .data2_o         (data2_o),
        .ALUCtrl_o       (ALUCtrl_o),
        .store_data_o    (store_data_o),
        .rd_o            (rd_o),
        .ctrl_o          (ctrl_o),
        .valid_o         (valid_o),
        .hazard_o        (hazard_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                          input logic [2:0] f3, input logic f7, input logic [1:0] op,
                          input logic src, input logic [3:0] ctrl);
        id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
        id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
        id_funct3_i = f3; id_funct7b5_i = f7; id_alu_op_i = op;
        id_alu_src_i = src; id_ctrl_i = ctrl;
    endtask

    task automatic clear_fwd();
        exm_rd_i = 0; exm_reg_write_i = 0; exm_result_i = 0;
        mwb_rd_i = 0; mwb_reg_write_i = 0; mwb_result_i = 0;
    endtask

    initial begin
        rst_i = 1'b0; stall_i = 0; flush_i = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clear_fwd();
        #2;
        check("rst_valid", valid_o, 0);
        check("rst_ctrl", ctrl_o, 0);
        check("rst_alu", ALUCtrl_o, 0);
        check("rst_hazard", hazard_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Plain R-type add capture
        set_id(1, 2, 3, 64'h10, 64'h20, 0, 3'b000, 0, 2'b10, 0, 4'b1000);
        tick();
        check("cap_valid", valid_o, 1);
        check("cap_data1", data1_o, 64'h10);
        check("cap_data2", data2_o, 64'h20);
        check("cap_rd", rd_o, 3);
        check("cap_ctrl", ctrl_o, 4'b1000);
        check("cap_alu", ALUCtrl_o, 3'b000);

        // Decode sweep
        set_id(1, 2, 3, 64'h10, 64'h20, 0, 3'b101, 1, 2'b10, 0, 4'b1000);
        tick(); check("dec_sra", ALUCtrl_o, 3'b110);
        id_funct7b5_i = 0;
        tick(); check("dec_srl", ALUCtrl_o, 3'b111);
        id_alu_op_i = 2'b11; id_funct3_i = 3'b000; id_funct7b5_i = 1;
        tick(); check("dec_addi", ALUCtrl_o, 3'b000);
        id_alu_op_i = 2'b10;
        tick(); check("dec_sub_r", ALUCtrl_o, 3'b001);
        id_alu_op_i = 2'b01; id_funct3_i = 3'b111;
        tick(); check("dec_op01", ALUCtrl_o, 3'b001);
        id_alu_op_i = 2'b10;
        tick(); check("dec_and", ALUCtrl_o, 3'b010);
        id_funct3_i = 3'b100;
        tick(); check("dec_xor", ALUCtrl_o, 3'b100);

        // Forwarding priority
        set_id(5, 2, 3, 64'h1111, 64'h20, 0, 3'b000, 0, 2'b00, 0, 4'b1000);
        exm_rd_i = 5; exm_reg_write_i = 1; exm_result_i = 64'hAAAA;
        mwb_rd_i = 5; mwb_reg_write_i = 1; mwb_result_i = 64'hBBBB;
        tick(); check("fwd_exm", data1_o, 64'hAAAA);
        exm_reg_write_i = 0;
        #1; check("fwd_mwb", data1_o, 64'hBBBB);
        mwb_reg_write_i = 0;
        #1; check("fwd_none", data1_o, 64'h1111);
        set_id(0, 2, 3, 64'h1234, 64'h20, 0, 3'b000, 0, 2'b00, 0, 4'b1000);
        exm_rd_i = 0; exm_reg_write_i = 1; mwb_rd_i = 0; mwb_reg_write_i = 1;
        tick(); check("fwd_x0", data1_o, 64'h1234);
        clear_fwd();

        // Immediate operand with forwarded store data
        set_id(1, 6, 3, 64'h10, 64'h66, 64'hFFFF_FFFF_FFFF_FFF0, 3'b000, 0, 2'b00, 1, 4'b0010);
        exm_rd_i = 6; exm_reg_write_i = 1; exm_result_i = 64'h7777;
        tick();
        check("src_data2", data2_o, 64'hFFFF_FFFF_FFFF_FFF0);
        check("src_store", store_data_o, 64'h7777);
        clear_fwd();
        #1; check("src_store_reg", store_data_o, 64'h66);

        // Load-use: ld x7 in EX, dependent reads x7 as rs2
        set_id(1, 2, 7, 64'h10, 64'h20, 64'h8, 3'b011, 0, 2'b00, 1, 4'b1101);
        tick();
        check("ld_ctrl", ctrl_o, 4'b1101);
        set_id(8, 7, 9, 64'h81, 64'h82, 0, 3'b110, 0, 2'b10, 0, 4'b1000);
        #1; check("lu_hazard", hazard_o, 1);
        tick();
        check("lu_bub_valid", valid_o, 0);
        check("lu_bub_ctrl", ctrl_o, 0);
        check("lu_bub_rd", rd_o, 0);
        check("lu_bub_hazard", hazard_o, 0);
        tick();
        check("lu_cap_valid", valid_o, 1);
        check("lu_cap_rd", rd_o, 9);
        check("lu_cap_alu", ALUCtrl_o, 3'b011);
        check("lu_cap_data2", data2_o, 64'h82);

        // Stall holds for three cycles
        stall_i = 1;
        set_id(3, 4, 10, 64'hDEAD, 64'hBEEF, 0, 3'b100, 0, 2'b10, 0, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rd", rd_o, 9);
            check("stall_data1", data1_o, 64'h81);
        end
        check("stall_valid", valid_o, 1);

        // Flush wins over stall
        flush_i = 1;
        tick();
        check("flush_valid", valid_o, 0);
        check("flush_rd", rd_o, 0);
        check("flush_ctrl", ctrl_o, 0);
        stall_i = 0; flush_i = 0;
        tick();
        check("post_flush_rd", rd_o, 10);
        check("post_flush_alu", ALUCtrl_o, 3'b100);

        // Asynchronous reset mid-stream
        rst_i = 0;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_rd", rd_o, 0);
        check("arst_data1", data1_o, 0);
        check("arst_alu", ALUCtrl_o, 0);
        @(negedge clk_i);
        rst_i = 1;
        tick();
        check("arst_recap_valid", valid_o, 1);
        check("arst_recap_data1", data1_o, 64'hDEAD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
